pipe_stage_skid: RTL

- Generic parametrised pipeline-stage register. Successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latch stages.
- Carries a control bundle and a data bundle between stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered ready_o), stall, and flush-to-bubble.
- Instantiated between every pair of CPU pipeline stages, with widths set per boundary.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_perf_ctr.sv | 25 ++
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and per-boundary widths for pipeline stages
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int DATA_LEN  = 32;
  localparam int ALUOP_LEN = 2;

  // RegWrite, MemtoReg, MemWrite, MemRead, Branch, ALUSrc, ALUOp
  localparam int IDEX_CTRL_W  = 6 + ALUOP_LEN;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_CTRL_W = 2;

endpackage

// File: rtl/pipe_perf_ctr.sv
// rtl/pipe_perf_ctr.sv - saturating event counter, synchronous active-low clear
module pipe_perf_ctr
  import pipe_pkg::*;
#(
  parameter int W = DATA_LEN
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage register with 2-entry skid, stall and flush; PIPE_STAGE_PERF_EN adds counters
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = IDEX_CTRL_W,
  parameter int DATA_W     = DATA_LEN,
  parameter int NUM_FIELDS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [CTRL_W-1:0]            ctrl_i,
  input  logic [DATA_W*NUM_FIELDS-1:0] data_i,
  input  logic                         stall_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [CTRL_W-1:0]            ctrl_o,
  output logic [DATA_W*NUM_FIELDS-1:0] data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]                  stall_cnt_o,
  output logic [31:0]                  bubble_cnt_o
`endif
);

  localparam int DW = DATA_W * NUM_FIELDS;

  pipe_state_e       r_state;
  logic              r_ready;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DW-1:0]     r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DW-1:0]     r_skid_data;

  logic w_valid;
  logic w_in_fire;
  logic w_out_fire;

  assign w_valid    = (r_state != EMPTY);
  assign w_in_fire  = valid_i & r_ready;
  assign w_out_fire = w_valid & ready_i & ~stall_i;

  // r_ready always equals (state != TWO), so it is set alongside every state change
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state     <= EMPTY;
      r_ready     <= 1'b1;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush_i) begin
      r_state     <= EMPTY;
      r_ready     <= 1'b1;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main_ctrl <= ctrl_i;
            r_main_data <= data_i;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_ctrl <= ctrl_i;
            r_main_data <= data_i;
          end else if (w_in_fire) begin
            r_skid_ctrl <= ctrl_i;
            r_skid_data <= data_i;
            r_state     <= TWO;
            r_ready     <= 1'b0;
          end else if (w_out_fire) begin
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_state     <= ONE;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = w_valid;
  assign ctrl_o  = w_valid ? r_main_ctrl : '0;
  assign data_o  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_ctr #(.W(32)) u_stall_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_valid & ~w_out_fire),
    .cnt_o (stall_cnt_o)
  );

  pipe_perf_ctr #(.W(32)) u_bubble_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~w_valid),
    .cnt_o (bubble_cnt_o)
  );
`endif

endmodule
